pulse_stretcher: RTL
====================

# pulse_stretcher

Output-side counterpart of the input debouncer. It accepts single-cycle event pulses, such as a one-shot from a button or a done strobe from the multiplier. It turns each pulse into a human-visible output pulse with a fixed on-time and a fixed off-time. Events that arrive while an output pulse is in progress are queued in a saturating counter and replayed in order, so no event is merged or shortened. It drives LEDs or other indicators on the board.

## Interface
- FREQUENCY, 10_000, clk frequency in Hz.
- HOLD_TIME, 0.03, output on-time in seconds (real).
- GAP_TIME, 0.03, minimum off-time after each output pulse, in seconds (real).
- MAX_PENDING, 7, maximum number of queued events (≥1).
- Derived values:
  - HOLD_CYCLES = FREQUENCY*HOLD_TIME, integer-rounded, must be ≥1.
  - GAP_CYCLES = FREQUENCY*GAP_TIME, integer-rounded, must be ≥1.
  - PW = $clog2(MAX_PENDING+1).
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- pulse_in  input  1  event strobe, one cycle per event; a level held N cycles counts as N events.
- clear  input  1  synchronous abort; drops the current pulse and the whole queue.
- led_out  output  1  stretched pulse, registered.
- busy  output  1  high whenever state ≠ IDLE, registered.
- pending  output  PW  number of queued events not yet started.
- overflow  output  1  one-cycle strobe when an event is dropped because the queue is full.

## Operation
- FSM states: IDLE, HOLD, GAP. A single down-counter `cnt` is shared by HOLD and GAP and is sized for max(HOLD_CYCLES, GAP_CYCLES).
- IDLE:
  - pulse_in=1 → go to HOLD and load cnt=HOLD_CYCLES-1.
  - pending is always 0 in IDLE.
- HOLD:
  - cnt decrements each cycle.
  - When cnt==0, go to GAP and load cnt=GAP_CYCLES-1.
- GAP:
  - cnt decrements each cycle.
  - When cnt==0 and pending>0: go to HOLD, reload cnt=HOLD_CYCLES-1, and decrement pending.
  - When cnt==0 and pending==0: go to IDLE.
- pulse_in in HOLD or GAP:
  - pending<MAX_PENDING → pending+1.
  - pending==MAX_PENDING → event dropped, overflow=1 for one cycle, pending unchanged.
- Simultaneous events:
  - GAP end with pending==0 and pulse_in=1 in the same cycle: go directly to HOLD; pending stays 0. This is a zero-idle restart.
  - GAP end with pending>0 and pulse_in=1 in the same cycle: pending is unchanged (one dequeued, one enqueued). overflow is never raised in this case, even if pending==MAX_PENDING.
- clear:
  - Has priority over pulse_in and over all timing.
  - Next cycle: state=IDLE, cnt=0, pending=0, led_out=0, busy=0, overflow=0.
  - A pulse_in in the same cycle as clear is discarded without raising overflow.
- Output decode:
  - led_out = (next state == HOLD), registered.
  - busy = (next state ≠ IDLE), registered.

## Timing
- Reset values: state=IDLE, cnt=0, pending=0, led_out=0, busy=0, overflow=0.
- Reset mid-pulse forces these values immediately, without waiting for a clock edge.
- Latency: pulse_in sampled at edge t → led_out=1 and busy=1 from edge t+1.
- An isolated event gives led_out high for exactly HOLD_CYCLES cycles, then low for exactly GAP_CYCLES cycles while busy stays 1. busy falls at the same edge on which GAP ends.
- Back-to-back queued events give the waveform HOLD_CYCLES high / GAP_CYCLES low, repeated with no extra idle cycle.
- A pulse_in at edge t updates pending at edge t+1.
- overflow is asserted at edge t+1 for exactly one cycle.
- pending never exceeds MAX_PENDING and never wraps below 0.

## Test plan
All scenarios use FREQUENCY=1_000, HOLD_TIME=0.005, GAP_TIME=0.003, MAX_PENDING=2, giving HOLD_CYCLES=5 and GAP_CYCLES=3.
- Single pulse at cycle 10 → led_out=1 on cycles 11–15 and 0 from 16; busy=1 on cycles 11–18 and 0 from 19; pending stays 0.
- Pulses at cycles 10, 12, 13 → pending goes 1 at cycle 13, 2 at cycle 14; led_out high on 11–15, 19–23, 27–31; busy falls at cycle 35.
- Pulses at cycles 10, 11, 12, 13 → overflow=1 on cycle 14 only; pending saturates at 2; exactly three output pulses are produced.
- Pulse at cycle 10, second pulse at cycle 18 (last GAP cycle) → led_out high 11–15 and 19–23 with no idle gap beyond the 3 GAP cycles; pending stays 0 throughout.
- Pulses at cycles 10 and 11, clear=1 at cycle 13 → from cycle 14: led_out=0, busy=0, pending=0, and no further output pulse. A pulse at cycle 20 then restarts normally with led_out high on 21–25.
- rst asserted asynchronously at cycle 12.5, during HOLD with pending=1 → all outputs 0 immediately. After release, the block is idle and no queued pulse replays.

Source files
------------

// File: rtl/pulse_stretcher_if.sv
// Event/indicator bundle for pulse_stretcher.
//   pulse_in : event strobe into the stretcher
//   clear    : synchronous abort of the current pulse and the queue
//   led_out  : stretched, registered indicator pulse
//   busy     : stretcher is in HOLD or GAP
//   pending  : queued events not yet started (PW bits)
//   overflow : one-cycle strobe, an event was dropped because the queue was full
// The master modport drives events; the slave modport is the stretcher itself.
interface pulse_stretcher_if #(
  parameter int PW = 3
);
  logic          pulse_in;
  logic          clear;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  modport master (
    output pulse_in, clear,
    input  led_out, busy, pending, overflow
  );

  modport slave (
    input  pulse_in, clear,
    output led_out, busy, pending, overflow
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Turns single-cycle event strobes into human-visible indicator pulses with a
// fixed on-time (HOLD) and a fixed off-time (GAP). Events that arrive while a
// pulse is in progress are counted in a saturating queue and replayed in order.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : pulse_stretcher_if.slave (pulse_in, clear in; led_out, busy,
//          pending, overflow out)
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no pulse in progress, queue empty
// HOLD  | led_out high, cnt counts down the on-time
// GAP   | led_out low, cnt counts down the mandatory off-time
module pulse_stretcher #(
  parameter int  FREQUENCY   = 10_000,
  parameter real HOLD_TIME   = 0.03,
  parameter real GAP_TIME    = 0.03,
  parameter int  MAX_PENDING = 7
) (
  input  logic               clk,
  input  logic               rst,
  pulse_stretcher_if.slave   bus
);

  localparam int HOLD_CYCLES = $rtoi(real'(FREQUENCY) * HOLD_TIME + 0.5);
  localparam int GAP_CYCLES  = $rtoi(real'(FREQUENCY) * GAP_TIME + 0.5);
  localparam int PW          = $clog2(MAX_PENDING + 1);
  localparam int MAX_CYCLES  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW          = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          ovf_d;
  logic          enq;
  logic          led_q, busy_q, ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      led_q   <= (state_d == HOLD);
      busy_q  <= (state_d != IDLE);
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = 1'b0;
    enq     = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.pulse_in) begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
        HOLD: begin
          enq = bus.pulse_in;
          if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            if (pend_q != '0) begin
              // Dequeue one; a coincident new event takes its slot, so the
              // count is left alone and overflow cannot occur here.
              state_d = HOLD;
              cnt_d   = HOLD_LOAD;
              if (!bus.pulse_in) pend_d = pend_q - 1'b1;
            end else if (bus.pulse_in) begin
              // Zero-idle restart straight into the next pulse.
              state_d = HOLD;
              cnt_d   = HOLD_LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
            enq   = bus.pulse_in;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          pend_d  = '0;
        end
      endcase
      if (enq) begin
        if (pend_q == PEND_MAX) ovf_d = 1'b1;
        else                    pend_d = pend_q + 1'b1;
      end
    end
  end

  assign bus.led_out  = led_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;

endmodule
